// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async read ports, two write ports (port 1 wins on same address),
// post-reset clear sweep with busy, optional hardwired zero entry. Optional write-through: REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    output logic                     busy,
    output logic                     wr_conflict
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok, we0_eff, we1_eff, conflict_nxt, clearing;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign busy     = (state == CLEAR);
    assign clearing = (state == CLEAR) && !rst;
    // A reset edge never commits a write, even one issued while READY.
    assign wr_ok        = (state == READY) && !rst;
    assign we0_eff      = wr_ok && we0 && !is_zero(waddr0);
    assign we1_eff      = wr_ok && we1 && !is_zero(waddr1);
    assign conflict_nxt = wr_ok && we0 && we1 && (waddr0 == waddr1);

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        if (rst) begin
            state_nxt   = CLEAR;
            clr_ptr_nxt = '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                    if (clr_ptr == LAST) state_nxt = READY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state   <= state_nxt;
        clr_ptr <= clr_ptr_nxt;
        if (rst) wr_conflict <= 1'b0;
        else     wr_conflict <= conflict_nxt;
    end

    // Port 1 is assigned last so it overrides port 0 on a shared address.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (we0_eff) mem[waddr0] <= wdata0;
            if (we1_eff) mem[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
        always_comb begin
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (we1_eff && (waddr1 == ra))      rv = wdata1;
            else if (we0_eff && (waddr0 == ra)) rv = wdata0;
`endif
            if (busy || is_zero(ra)) rv = '0;
        end
        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: reset sweep, table-driven read/write rows with a read scoreboard,
// mid-sweep reset and same-cycle write/read hand sequences.
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic            we0, we1;
    logic [AW-1:0]   waddr0, waddr1;
    logic [DW-1:0]   wdata0, wdata1;
    logic            busy, wr_conflict;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .busy(busy), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
        logic          exp_conf;
    } row_t;

    logic [2*DW-1:0] sb[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        rd_addr = {r1, r0};
    endtask

    // Counts edges until busy falls; bounded so a stuck FSM still reaches the summary.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            edge1();
            n++;
        end
    endtask

    // Pops the expected pair and compares against the combinational read ports.
    task automatic sb_check(input string name);
        logic [2*DW-1:0] e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, "_rd0"}, rd_data[DW-1:0], e[DW-1:0]);
            check({name, "_rd1"}, rd_data[2*DW-1:DW], e[2*DW-1:DW]);
        end
    endtask

    row_t tbl[11];
    int   n;
    logic [DW-1:0] exp_byp;

    initial begin
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 2,  0,            0,            0};
        tbl[1]  = '{0, 0, 0,            0, 0, 0,          5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0};
        tbl[2]  = '{1, 9, 32'h11,       1, 9, 32'h22,     5, 0,  32'hDEADBEEF, 0,            1};
        tbl[3]  = '{0, 0, 0,            0, 0, 0,          9, 9,  32'h22,       32'h22,       0};
        tbl[4]  = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 9, 5, 32'h22,      32'hDEADBEEF, 0};
        tbl[5]  = '{1, 10, 32'hA,       1, 11, 32'hB,     0, 0,  0,            0,            0};
        tbl[6]  = '{0, 0, 0,            0, 0, 0,          10, 11, 32'hA,       32'hB,        0};
        tbl[7]  = '{1, 0, 32'h1,        1, 0, 32'h2,      10, 11, 32'hA,       32'hB,        1};
        tbl[8]  = '{0, 0, 0,            0, 0, 0,          0, 31, 0,            0,            0};
        tbl[9]  = '{1, 31, 32'h1234,    1, 30, 32'h5678,  11, 10, 32'hB,       32'hA,        0};
        tbl[10] = '{0, 0, 0,            0, 0, 0,          31, 30, 32'h1234,    32'h5678,     0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        edge1();
        edge1();
        check("reset_busy", {31'b0, busy}, 1);
        check("reset_conflict", {31'b0, wr_conflict}, 0);
        rst = 1'b0;
        count_busy(n);
        check("sweep_edges", n, DEPTH);
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            #1;
            check($sformatf("swept_%0d", a), rd_data[DW-1:0], 0);
            check($sformatf("swept_%0d", a + 1), rd_data[2*DW-1:DW], 0);
        end

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].we0, tbl[i].wa0, tbl[i].wd0, tbl[i].we1, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].ra0, tbl[i].ra1);
            sb.push_back({tbl[i].exp1, tbl[i].exp0});
            @(negedge clk);
            sb_check($sformatf("row%0d", i));
            edge1();
            check($sformatf("row%0d_conf", i), {31'b0, wr_conflict}, {31'b0, tbl[i].exp_conf});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        edge1();
        check("conf_clears", {31'b0, wr_conflict}, 0);

        // Same-cycle write and read of address 7; zero entry never bypasses.
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5;
`else
        exp_byp = 32'h0;
`endif
        drive(1, 7, 32'hA5, 1, 0, 32'h55, 7, 0);
        sb.push_back({32'h0, exp_byp});
        @(negedge clk);
        sb_check("bypass");
        edge1();
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        sb.push_back({32'hA5, 32'hA5});
        @(negedge clk);
        sb_check("after_wr7");

        // Reset from READY, then re-pulse reset at clr_ptr=10 with a write pending.
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) edge1();
        drive(1, 3, 32'h33, 1, 3, 32'h44, 31, 30);
        #1;
        check("busy_rd_gated", rd_data[DW-1:0], 0);
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        check("mid_busy", {31'b0, busy}, 1);
        check("mid_no_conf", {31'b0, wr_conflict}, 0);
        drive(0, 0, 0, 0, 0, 0, 3, 31);
        count_busy(n);
        check("mid_sweep_edges", n, DEPTH);
        #1;
        check("mid_mem3", rd_data[DW-1:0], 0);
        check("mid_mem31", rd_data[2*DW-1:DW], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
